glyph_stroke_sequencer: RTL and testbench
=========================================

# glyph_stroke_sequencer

Sequences a glyph stroke ROM (the per-digit `numN` tables) into a pen-plotter motion engine. The block latches a digit on `start` and walks the stroke index from 0 to the glyph's last stroke. For each stroke it captures the segment endpoints, handles the pen servo (lift/lower plus settle delay), issues one move command over a valid/ready handshake, and waits for motion completion before advancing. It sits between the top-level drawing FSM and the glyph ROM mux / line-motion engine.

## Interface
- `PEN_SETTLE`, default 4: cycles to wait after any pen state change before issuing a move (≥1).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: draw request; sampled only in IDLE.
- `glyph` in 4: digit 0–9, latched on accepted `start`.
- `abort` in 1: terminate drawing; level-sampled each cycle.
- `glyph_sel` out 4: latched digit, drives the ROM mux.
- `rom_en` out 1: ROM enable.
- `rom_idx` out 5: stroke index.
- `rom_sx`, `rom_sy`, `rom_ex`, `rom_ey` in 8 each: ROM segment endpoints (combinational from `rom_idx`).
- `rom_pen` in 1: ROM pen_down for the stroke.
- `mv_valid` out 1; `mv_ready` in 1: move command handshake.
- `mv_sx`, `mv_sy`, `mv_ex`, `mv_ey` out 8 each: registered move endpoints.
- `mv_done` in 1: one-cycle pulse from the motion engine when the accepted move finishes.
- `pen` out 1: pen servo command, 1 = down.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on return to IDLE (normal or aborted).

## Operation
- States: IDLE, FETCH, SETTLE, ISSUE, WAIT, LIFT.
- **IDLE**
  - `start` with `glyph` ≤ 9: latch `glyph_sel`, set k = 0, go to FETCH.
  - `glyph` > 9: ignore `start`; stay in IDLE with no `done`.
- **FETCH** (1 cycle): `rom_en` = 1, `rom_idx` = k.
  - Capture the ROM endpoints into `mv_*`.
  - If `rom_pen` ≠ `pen`: set `pen` = `rom_pen` on the transition and go to SETTLE.
  - Otherwise go to ISSUE.
- **SETTLE**: counter runs for `PEN_SETTLE` cycles, then go to ISSUE.
- **ISSUE**: `mv_valid` = 1. `mv_*` are held stable until `mv_ready`; on the handshake go to WAIT.
- **WAIT**: on `mv_done`:
  - If k = `STROKE_COUNT[glyph_sel]` − 1, go to LIFT.
  - Otherwise k = k + 1 and go to FETCH.
- **LIFT**
  - If `pen` = 1: set `pen` = 0, wait `PEN_SETTLE` cycles, then go to IDLE with the `done` pulse.
  - If `pen` = 0: go to IDLE with `done` on the next cycle.
- **Abort** in FETCH, SETTLE, ISSUE or WAIT: drop `mv_valid`, go to LIFT. The bench must not see `mv_valid` after the abort cycle.
  - `abort` and `mv_ready` together in ISSUE: the handshake counts as accepted; the block still goes to LIFT and does not wait for `mv_done`.
  - `abort` in IDLE or LIFT: ignored.
- A `mv_done` received outside WAIT is ignored.
- `rom_en` = 0 and `rom_idx` = 0 outside FETCH.
- k is 5 bits; `STROKE_COUNT` ≤ 31, so k never wraps.

## Timing
- **Reset values:**
  - state IDLE, k = 0;
  - `glyph_sel` = 0, `rom_idx` = 0, `rom_en` = 0;
  - `mv_valid` = 0, all `mv_*` = 0;
  - `pen` = 0, `busy` = 0, `done` = 0.
- **Start latency:** `start` sampled at edge n → FETCH during cycle n+1 → `mv_valid` at n+2 when no pen change, or at n+2+`PEN_SETTLE` with a pen change.
- **Per-stroke overhead** after `mv_done`: 1 FETCH cycle, plus `PEN_SETTLE` if the pen changes.
- **Outputs:** all outputs are registered; `done` is high exactly one cycle, coincident with the first IDLE cycle.
- **Reset mid-draw:** immediate return to reset values; `pen` goes to 0 asynchronously.

## Structure
- Shared package `glyph_pkg`:
  - `STROKE_COUNT[0:9]` constant array (digit 5 = 7);
  - coordinate width `COORD_W` = 8;
  - stroke index width `IDX_W` = 5;
  - state enum.
- Sub-module `settle_timer`: loadable down-counter with a `zero` flag, used by SETTLE and LIFT.
- The ROM mux stays outside this block.

## Test plan
- **Normal draw:** glyph 5, `PEN_SETTLE` = 4, `mv_ready` = 1, `mv_done` 3 cycles after accept → 7 moves in order: (0,0)→(60,120) pen 0; (60,120)→(60,40) preceded by `pen` rising and 4 settle cycles; … ; (180,40)→(0,0) preceded by `pen` falling. Then `done` with no LIFT settle.
- **Backpressure:** `mv_ready` low 10 cycles on stroke 2 → `mv_valid` and `mv_*` = (60,40,120,40) held constant throughout; exactly one accept.
- **Abort in SETTLE:** abort before stroke 1 issues → no `mv_valid`; `pen` returns to 0; `done` 4 cycles later; next `start` works.
- **Abort with simultaneous handshake** in ISSUE → handshake counted; LIFT entered; subsequent `mv_done` ignored; single `done`.
- **Invalid glyph:** `start` with glyph 12 → `busy` stays 0, no `done`, no ROM access.
- **Mid-draw reset:** `rst` during WAIT → all outputs at reset values the same cycle; a later `start` with glyph 5 replays from stroke 0.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph stroke sequencer.
package glyph_pkg;
  localparam int COORD_W = 8;
  localparam int IDX_W   = 5;

  localparam logic [IDX_W-1:0] STROKE_COUNT [0:9] = '{
    5'd3, 5'd2, 5'd5, 5'd6, 5'd4, 5'd7, 5'd6, 5'd2, 5'd8, 5'd6
  };

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_ISSUE, S_WAIT, S_LIFT
  } state_t;

  // Only digits 0-9 are ever latched, so other codes never reach this lookup.
  function automatic logic [IDX_W-1:0] stroke_count(input logic [3:0] g);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < 10; i++)
      if (g == 4'(i)) n = STROKE_COUNT[i];
    return n;
  endfunction
endpackage

// File: rtl/glyph_stroke_sequencer_settle_timer.sv
// Loadable down-counter that paces pen servo settling.
module settle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/glyph_stroke_sequencer.sv
// Walks a glyph's strokes: fetch endpoints, settle pen, issue move, wait for completion.
module glyph_stroke_sequencer
  import glyph_pkg::*;
#(
  parameter int PEN_SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         glyph,
  input  logic               abort,
  output logic [3:0]         glyph_sel,
  output logic               rom_en,
  output logic [IDX_W-1:0]   rom_idx,
  input  logic [COORD_W-1:0] rom_sx,
  input  logic [COORD_W-1:0] rom_sy,
  input  logic [COORD_W-1:0] rom_ex,
  input  logic [COORD_W-1:0] rom_ey,
  input  logic               rom_pen,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [COORD_W-1:0] mv_sx,
  output logic [COORD_W-1:0] mv_sy,
  output logic [COORD_W-1:0] mv_ex,
  output logic [COORD_W-1:0] mv_ey,
  input  logic               mv_done,
  output logic               pen,
  output logic               busy,
  output logic               done
);
  localparam int TW = 16;

  state_t           state;
  logic [IDX_W-1:0] k;
  logic             lift_wait;
  logic             active, last, lift_go, tmr_load, tmr_dec, tmr_zero;

  always_comb begin
    active   = (state == S_FETCH) || (state == S_SETTLE) ||
               (state == S_ISSUE) || (state == S_WAIT);
    last     = (k == stroke_count(glyph_sel) - IDX_W'(1));
    lift_go  = (active && abort) || (state == S_WAIT && mv_done && last);
    tmr_load = (lift_go && pen) || (state == S_FETCH && !abort && rom_pen != pen);
    tmr_dec  = (state == S_SETTLE) || (state == S_LIFT && lift_wait);
  end

  settle_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (TW'(PEN_SETTLE - 1)),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      lift_wait <= 1'b0;
      glyph_sel <= '0;
      rom_en    <= 1'b0;
      rom_idx   <= '0;
      mv_valid  <= 1'b0;
      mv_sx     <= '0;
      mv_sy     <= '0;
      mv_ex     <= '0;
      mv_ey     <= '0;
      pen       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rom_en  <= 1'b0;
      rom_idx <= '0;
      // Abort and end-of-glyph share one exit; a handshake in the same cycle still completes on the bus.
      if (lift_go) begin
        state     <= S_LIFT;
        mv_valid  <= 1'b0;
        lift_wait <= pen;
        pen       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start && glyph <= 4'd9) begin
            glyph_sel <= glyph;
            k         <= '0;
            rom_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
          S_FETCH: begin
            mv_sx <= rom_sx;
            mv_sy <= rom_sy;
            mv_ex <= rom_ex;
            mv_ey <= rom_ey;
            if (rom_pen != pen) begin
              pen   <= rom_pen;
              state <= S_SETTLE;
            end else begin
              mv_valid <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_SETTLE: if (tmr_zero) begin
            mv_valid <= 1'b1;
            state    <= S_ISSUE;
          end
          S_ISSUE: if (mv_ready) begin
            mv_valid <= 1'b0;
            state    <= S_WAIT;
          end
          S_WAIT: if (mv_done) begin
            k       <= k + IDX_W'(1);
            rom_en  <= 1'b1;
            rom_idx <= k + IDX_W'(1);
            state   <= S_FETCH;
          end
          S_LIFT: if (!lift_wait || tmr_zero) begin
            lift_wait <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_glyph_stroke_sequencer.sv
// Directed + randomized bench: ROM and motion engine models, move scoreboard, timing checks.
module tb_glyph_stroke_sequencer;
  localparam int PS = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] glyph, glyph_sel;
  logic       rom_en, rom_pen;
  logic [4:0] rom_idx;
  logic [7:0] rom_sx, rom_sy, rom_ex, rom_ey;
  logic       mv_valid, mv_ready, mv_done;
  logic [7:0] mv_sx, mv_sy, mv_ex, mv_ey;
  logic       pen, busy, done;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [7:0] sx, sy, ex, ey; logic pen;} seg_t;
  typedef struct {seg_t s; int lat;} acc_t;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input int g);
    case (g)
      0: return 3; 1: return 2; 2: return 5; 3: return 6; 4: return 4;
      5: return 7; 6: return 6; 7: return 2; 8: return 8; default: return 6;
    endcase
  endfunction

  function automatic seg_t ref_seg(input int g, input int i);
    seg_t s;
    if (g == 5) begin
      case (i)
        0: s = '{8'd0,   8'd0,   8'd60,  8'd120, 1'b0};
        1: s = '{8'd60,  8'd120, 8'd60,  8'd40,  1'b1};
        2: s = '{8'd60,  8'd40,  8'd120, 8'd40,  1'b1};
        3: s = '{8'd120, 8'd40,  8'd120, 8'd120, 1'b1};
        4: s = '{8'd120, 8'd120, 8'd180, 8'd120, 1'b1};
        5: s = '{8'd180, 8'd120, 8'd180, 8'd40,  1'b1};
        default: s = '{8'd180, 8'd40, 8'd0, 8'd0, 1'b0};
      endcase
    end else begin
      s.sx  = 8'(g * 20 + i * 3);
      s.sy  = 8'(i * 7);
      s.ex  = 8'(g * 20 + i * 3 + 5);
      s.ey  = 8'(i * 7 + 11);
      s.pen = ((i / 2 + g) % 2) != 0;
    end
    return s;
  endfunction

  seg_t rom_s;
  always_comb rom_s = ref_seg(int'(glyph_sel), int'(rom_idx));
  assign rom_sx = rom_s.sx;
  assign rom_sy = rom_s.sy;
  assign rom_ex = rom_s.ex;
  assign rom_ey = rom_s.ey;
  assign rom_pen = rom_s.pen;

  glyph_stroke_sequencer #(.PEN_SETTLE(PS)) dut (
    .clk(clk), .rst(rst), .start(start), .glyph(glyph), .abort(abort),
    .glyph_sel(glyph_sel), .rom_en(rom_en), .rom_idx(rom_idx),
    .rom_sx(rom_sx), .rom_sy(rom_sy), .rom_ex(rom_ex), .rom_ey(rom_ey), .rom_pen(rom_pen),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_sx(mv_sx), .mv_sy(mv_sy), .mv_ex(mv_ex), .mv_ey(mv_ey),
    .mv_done(mv_done), .pen(pen), .busy(busy), .done(done)
  );

  // Motion engine model and observer; acts on the falling edge.
  int   done_dly = 3, stall_pct = 0, hold_stroke = -1, hold_len = 0;
  logic ready_off = 1'b0;
  int   dcnt = 0, ref_cyc = 0, done_cnt = 0, done_cyc = 0, done_lat = 0;
  int   rise_n = 0, hold_ct = 0, rom_en_cnt = 0, pend_lat = 0, cur_g = 0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_mv = '0;
  acc_t q[$];
  acc_t a;
  seg_t hx;

  initial begin
    mv_ready = 1'b0;
    mv_done  = 1'b0;
    forever begin
      @(negedge clk);
      mv_done = 1'b0;
      if (rst) begin
        dcnt = 0; mv_ready = 1'b0; prev_valid = 1'b0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin mv_done = 1'b1; ref_cyc = cyc; end
        end
        if (start && !busy) begin
          q.delete(); rise_n = 0; hold_ct = 0; ref_cyc = cyc; cur_g = int'(glyph);
        end
        if (rom_en) rom_en_cnt++;
        if (done) begin
          done_cnt++; done_cyc = cyc; done_lat = cyc - ref_cyc;
          chk("done_not_busy", busy, 0);
        end
        if (mv_valid && !prev_valid) begin rise_n++; pend_lat = cyc - ref_cyc; end
        if (mv_valid && prev_valid) chk("mv_stable", {mv_sx, mv_sy, mv_ex, mv_ey}, prev_mv);
        if (ready_off) mv_ready = 1'b0;
        else if (mv_valid && q.size() == hold_stroke && hold_ct < hold_len) begin
          mv_ready = 1'b0;
          hold_ct++;
          hx = ref_seg(cur_g, hold_stroke);
          chk("bp_hold", {mv_sx, mv_sy, mv_ex, mv_ey}, {hx.sx, hx.sy, hx.ex, hx.ey});
        end else mv_ready = ($urandom_range(0, 99) >= stall_pct);
        if (mv_valid && mv_ready) begin
          a.s = '{mv_sx, mv_sy, mv_ex, mv_ey, pen};
          a.lat = pend_lat;
          q.push_back(a);
          dcnt = (done_dly > 0) ? done_dly : int'($urandom_range(1, 6));
        end
        prev_valid = mv_valid;
        prev_mv = {mv_sx, mv_sy, mv_ex, mv_ey};
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, ":outs"}, {glyph_sel, rom_en, rom_idx, mv_valid, mv_sx, mv_sy, mv_ex, mv_ey, busy, done}, 0);
    chk({tag, ":pen"}, pen, 0);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk); #1;
    start = 1'b1; glyph = 4'(g);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin @(negedge clk); #1; end
    chk({tag, ":done_cnt"}, done_cnt, d0 + 1);
  endtask

  task automatic run_glyph(input int g, input string tag);
    int d0, n, lat;
    logic pp;
    seg_t e;
    d0 = done_cnt;
    pulse_start(g);
    wait_done(tag, d0);
    n = ref_count(g);
    chk({tag, ":moves"}, q.size(), n);
    pp = 1'b0;
    for (int i = 0; i < n && i < q.size(); i++) begin
      e = ref_seg(g, i);
      lat = 2 + ((e.pen != pp) ? PS : 0);
      chk($sformatf("%s:seg%0d", tag, i), q[i].s, e);
      chk($sformatf("%s:lat%0d", tag, i), q[i].lat, lat);
      pp = e.pen;
    end
    chk({tag, ":done_lat"}, done_lat, pp ? (1 + PS) : 2);
    chk({tag, ":idle"}, {busy, pen, mv_valid}, 0);
    @(negedge clk); #1;
    chk({tag, ":done_1cyc"}, done, 0);
  endtask

  initial begin
    int d0, e0, ab, g;
    logic saw_busy;
    rst = 1'b1; start = 1'b0; abort = 1'b0; glyph = '0;
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, e0, ab, g;
    logic saw_busy;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    stall_pct = 0; done_dly = 3;
    run_glyph(5, "normal");

    hold_stroke = 2; hold_len = 10;
    run_glyph(5, "backpressure");
    chk("bp_hold_cycles", hold_ct, 10);
    hold_stroke = -1; hold_len = 0;

    for (int r = 0; r < 5; r++) begin
      g = int'($urandom_range(0, 9));
      stall_pct = int'($urandom_range(0, 60));
      done_dly = 0;
      run_glyph(g, $sformatf("rand%0d_g%0d", r, g));
    end

    // Abort while the pen settles before stroke 1.
    stall_pct = 0; done_dly = 3;
    d0 = done_cnt;
    pulse_start(5);
    for (int c = 0; c < 200 && !(q.size() == 1 && pen); c++) begin @(negedge clk); #1; end
    chk("abort_settle:pen_up", pen, 1);
    @(posedge clk); #1;
    abort = 1'b1; ab = cyc;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("abort_settle", d0);
    chk("abort_settle:done_time", done_cyc, ab + 1 + PS);
    chk("abort_settle:moves", q.size(), 1);
    chk("abort_settle:valids", rise_n, 1);
    chk("abort_settle:pen", pen, 0);
    run_glyph(2, "after_abort");

    // Abort coincident with the handshake.
    ready_off = 1'b1;
    d0 = done_cnt;
    pulse_start(5);
    for (int c = 0; c < 50 && !mv_valid; c++) begin @(negedge clk); #1; end
    chk("abort_hs:valid", mv_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1; ready_off = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("abort_hs", d0);
    repeat (12) @(negedge clk);
    #1;
    chk("abort_hs:single_done", done_cnt, d0 + 1);
    chk("abort_hs:accepts", q.size(), 1);
    chk("abort_hs:valids", rise_n, 1);
    chk("abort_hs:idle", {busy, mv_valid, pen}, 0);

    // Invalid glyph.
    d0 = done_cnt; e0 = rom_en_cnt; saw_busy = 1'b0;
    pulse_start(12);
    for (int c = 0; c < 15; c++) begin @(negedge clk); #1; saw_busy |= busy; end
    chk("invalid:busy", saw_busy, 0);
    chk("invalid:done", done_cnt, d0);
    chk("invalid:rom", rom_en_cnt, e0);

    // Reset during WAIT of stroke 1 (pen down).
    done_dly = 8;
    pulse_start(5);
    for (int c = 0; c < 200 && q.size() != 2; c++) begin @(negedge clk); #1; end
    chk("midrst:accepts", q.size(), 2);
    @(posedge clk); #1;
    chk("midrst:pre_pen", pen, 1);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_dly = 3;
    run_glyph(5, "replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
